audio_i2s_tx: RTL and testbench
===============================

AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of stereo sample entries buffered (power of two, 2..16).
REQ-002 SHALL have port clk_74a  input  1  sole clock, 74.25 MHz; all logic on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port sample_l  input  16  left sample, signed two's complement.
REQ-005 SHALL have port sample_r  input  16  right sample, signed two's complement.
REQ-006 SHALL have port sample_valid  input  1  producer offers {sample_l, sample_r}.
REQ-007 SHALL have port sample_ready  output  1  FIFO can accept; push = valid && ready.
REQ-008 SHALL have port audio_mclk  output  1  12.288 MHz average master clock to the codec.
REQ-009 SHALL have port audio_lrck  output  1  word select; 0 = left, 1 = right.
REQ-010 SHALL have port audio_dac  output  1  I2S serial data.
REQ-011 SHALL have port audio_sclk  output  1  bit clock, mclk/4, monitoring only.
REQ-012 SHALL have port underflow  output  1  one-cycle pulse: frame started with FIFO empty.
REQ-013 SHALL have port fifo_level  output  5  current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-014 SHALL add 245760 each cycle to a 22-bit accumulator; when the accumulator is >= 742500, it SHALL toggle audio_mclk and add 245760 - 742500 instead.
REQ-015 SHALL increment a 2-bit divider on each mclk 0->1 toggle, with audio_sclk = divider[1]; the sclk falling-edge event (divider 3->0) is a one-cycle internal strobe.
REQ-016 SHALL advance a 6-bit bit counter by 1, modulo 64, on each sclk falling-edge strobe; 64 bits form one 48 kHz frame.
REQ-017 SHALL update audio_lrck and audio_dac only on the sclk falling-edge strobe, registered.
REQ-018 SHALL set audio_lrck to new bit_cnt[5].
REQ-019 SHALL drive audio_dac with sample bit (16 - p) MSB-first for slot position p = bit_cnt[4:0] in 1..16; p = 0 and 17..31 SHALL be 0 (I2S one-bit delay, 16 pad bits).
REQ-020 SHALL, when bit_cnt wraps 63->0, pop one FIFO entry into the left/right holding registers if the FIFO is non-empty.
REQ-021 SHALL, when bit_cnt wraps 63->0 with the FIFO empty, load zeros into the holding registers and pulse underflow.
REQ-022 SHALL load the left holding register into the shifter at bit_cnt 0 and the right holding register at bit_cnt 32.
REQ-023 SHALL drive sample_ready = (fifo_level != FIFO_DEPTH), combinationally from registered state.
REQ-024 SHALL ignore sample_valid while sample_ready is low.
REQ-025 SHALL, on a push and a pop in the same cycle, apply both with fifo_level unchanged.
REQ-026 SHALL, on a push into an empty FIFO coinciding with a frame-start pop, not bypass: the frame is silent, underflow pulses, and the entry remains (level becomes 1).
REQ-027 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH with no gaps.

Reset
REQ-028 SHALL, while reset_n is low, hold accumulator, divider, bit counter, pointers and holding registers at 0.
REQ-029 SHALL, while reset_n is low, hold audio_mclk, audio_sclk, audio_lrck, audio_dac and underflow at 0, fifo_level at 0 and sample_ready at 1.
REQ-030 SHALL restart from the REQ-028/029 values when reset is asserted mid-frame, discarding FIFO contents.
REQ-031 SHALL begin mclk accumulation on the first clock after reset_n deasserts.

Structure
REQ-032 SHALL take from a shared package audio_pkg: MCLK_INC = 245760, MCLK_MOD = 742500, SAMPLE_W = 16, FRAME_BITS = 64.
REQ-033 SHALL contain one sub-module, sample_fifo (synchronous, same clock/reset, FIFO_DEPTH x 32 bits), used by this block.

Verification
REQ-034 SHALL check: reset release, 742500 cycles free-run -> exactly 122880 audio_mclk rising edges, 30720 audio_sclk rising edges.
REQ-035 SHALL check: push L=16'hA5C3, R=16'h0F0F -> next frame dac bits p1..16 = 1010010111000011 with lrck=0, then 0000111100001111 with lrck=1, pad bits 0.
REQ-036 SHALL check: no pushes after reset -> underflow pulses once per frame (every 1546 or 1547 cycles) and dac stays 0.
REQ-037 SHALL check: 5 consecutive pushes with FIFO_DEPTH=4 -> ready low after the 4th, 5th not accepted, fifo_level=4, frames then play entries 1..4 in order.
REQ-038 SHALL check: push coinciding with frame-start pop on empty FIFO -> underflow pulse, level=1, entry plays in the following frame.
REQ-039 SHALL check: reset_n low at bit_cnt=20 with 3 entries queued -> all outputs 0 and level 0 asynchronously, ready=1, clean restart after release.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants and types for the I2S audio transmitter.
// MCLK fractional divider, sample width and frame geometry.
package audio_pkg;

  localparam int MCLK_INC   = 245760;
  localparam int MCLK_MOD   = 742500;
  localparam int SAMPLE_W   = 16;
  localparam int FRAME_BITS = 64;

  localparam int ACC_W = 22;
  localparam int CNT_W = $clog2(FRAME_BITS);

  localparam logic [ACC_W-1:0] ACC_INC  = ACC_W'(MCLK_INC);
  localparam logic [ACC_W-1:0] ACC_MOD  = ACC_W'(MCLK_MOD);
  // INC - MOD is negative; modulo-2^22 add gives acc + INC - MOD
  localparam logic [ACC_W-1:0] ACC_WRAP = ACC_W'(MCLK_INC - MCLK_MOD);

  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } stereo_t;

endpackage

// File: rtl/sample_fifo.sv
// Stereo sample FIFO, DEPTH x 32 bits, single clock, async reset.
// Ports: push_i/din_i write, pop_i/dout_o read, empty/full/level status.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  stereo_t    din_i,
  input  logic       pop_i,
  output stereo_t    dout_o,
  output logic       empty_o,
  output logic       full_o,
  output logic [4:0] level_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  stereo_t       mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [4:0]    lvl_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (lvl_q == 5'(DEPTH));
  assign empty_o = (lvl_q == 5'd0);
  assign level_o = lvl_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      lvl_q <= lvl_q + 5'(do_push) - 5'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: fractional MCLK from 74.25 MHz, SCLK = MCLK/4,
// 64-bit frames, 16-bit MSB-first samples fed from a stereo FIFO.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk_74a,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                audio_mclk,
  output logic                audio_lrck,
  output logic                audio_dac,
  output logic                audio_sclk,
  output logic                underflow,
  output logic [4:0]          fifo_level
);

  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_d;
  logic                mclk_q;
  logic [1:0]          div_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                lrck_q;
  logic                dac_q;
  logic                und_q;
  logic [SAMPLE_W-1:0] hold_l_q;
  logic [SAMPLE_W-1:0] hold_r_q;
  logic [SAMPLE_W-1:0] shift_q;

  logic                tick;
  logic                rise;
  logic                fall_stb;
  logic                wrap;
  logic                slot_first;
  logic                slot_data;
  logic [CNT_W-2:0]    pos_d;
  logic [SAMPLE_W-1:0] src;

  stereo_t             push_data;
  stereo_t             fifo_dout;
  stereo_t             nxt;
  logic                fifo_empty;
  logic                fifo_full;
  logic                pop;

  assign push_data = '{l: sample_l, r: sample_r};

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_74a),
    .rst_ni  (reset_n),
    .push_i  (sample_valid),
    .din_i   (push_data),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  assign tick     = (acc_q >= ACC_MOD);
  assign acc_d    = acc_q + (tick ? ACC_WRAP : ACC_INC);
  assign rise     = tick && !mclk_q;
  assign fall_stb = rise && (div_q == 2'd3);
  assign cnt_d    = cnt_q + CNT_W'(1);
  assign wrap     = fall_stb && (cnt_q == CNT_W'(FRAME_BITS - 1));
  assign pop      = wrap && !fifo_empty;
  assign nxt      = fifo_empty ? '0 : fifo_dout;

  // Leaving slot 0 of a half-frame emits the MSB straight from the
  // holding register; the remaining 15 bits follow from the shifter.
  assign pos_d      = cnt_d[CNT_W-2:0];
  assign slot_first = (cnt_q[CNT_W-2:0] == '0);
  assign slot_data  = (pos_d >= (CNT_W-1)'(2)) &&
                      (pos_d <= (CNT_W-1)'(SAMPLE_W));
  assign src        = cnt_q[CNT_W-1] ? hold_r_q : hold_l_q;

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      acc_q    <= '0;
      mclk_q   <= 1'b0;
      div_q    <= '0;
      cnt_q    <= '0;
      lrck_q   <= 1'b0;
      dac_q    <= 1'b0;
      und_q    <= 1'b0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      shift_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      mclk_q <= mclk_q ^ tick;
      und_q  <= wrap && fifo_empty;
      if (rise) div_q <= div_q + 2'd1;
      if (fall_stb) begin
        cnt_q  <= cnt_d;
        lrck_q <= cnt_d[CNT_W-1];
        if (wrap) begin
          hold_l_q <= nxt.l;
          hold_r_q <= nxt.r;
        end
        unique case (1'b1)
          slot_first: begin
            dac_q   <= src[SAMPLE_W-1];
            shift_q <= {src[SAMPLE_W-2:0], 1'b0};
          end
          slot_data: begin
            dac_q   <= shift_q[SAMPLE_W-1];
            shift_q <= {shift_q[SAMPLE_W-2:0], 1'b0};
          end
          default: dac_q <= 1'b0;
        endcase
      end
    end
  end

  assign sample_ready = !fifo_full;
  assign audio_mclk   = mclk_q;
  assign audio_sclk   = div_q[1];
  assign audio_lrck   = lrck_q;
  assign audio_dac    = dac_q;
  assign underflow    = und_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx: closed-form clock model,
// captured-frame comparison, FIFO table vectors and reset corners.
module tb_audio_i2s_tx;

  localparam longint INC = 245760;
  localparam longint MOD = 742500;
  localparam logic [63:0] LRCK_EXP = {32'hFFFF_FFFF, 32'h0};

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        exp_ready;
    logic [4:0]  exp_level;
  } pvec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] sample_l = '0;
  logic [15:0] sample_r = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        audio_mclk;
  logic        audio_lrck;
  logic        audio_dac;
  logic        audio_sclk;
  logic        underflow;
  logic [4:0]  fifo_level;

  int total = 0;
  int bad = 0;
  longint cyc;
  logic [1:0] cap [$];
  logic sclk_prev;
  int und_cnt;
  pvec_t vec [5];

  audio_i2s_tx #(.FIFO_DEPTH(4)) dut (
    .clk_74a      (clk),
    .reset_n      (reset_n),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .audio_mclk   (audio_mclk),
    .audio_lrck   (audio_lrck),
    .audio_dac    (audio_dac),
    .audio_sclk   (audio_sclk),
    .underflow    (underflow),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else cyc <= cyc + 1;

  // capture {lrck,dac} at each sclk rise (receiver sampling point)
  always @(negedge clk) begin
    if (!reset_n) begin
      cap.delete();
      sclk_prev = 1'b0;
      und_cnt = 0;
    end else begin
      if (audio_sclk && !sclk_prev)
        cap.push_back({audio_lrck, audio_dac});
      sclk_prev = audio_sclk;
      if (underflow) und_cnt++;
    end
  end

  // mclk toggles completed after e clock edges since reset release
  function automatic longint tog(longint e);
    return (e <= 0) ? 0 : ((e - 1) * INC) / MOD;
  endfunction

  function automatic longint rises(longint e);
    return (tog(e) + 1) / 2;
  endfunction

  function automatic longint strobes(longint e);
    return rises(e) / 4;
  endfunction

  function automatic logic [63:0] exp_dac(logic [15:0] l,
                                          logic [15:0] r);
    logic [63:0] v;
    logic [15:0] s;
    int q;
    v = '0;
    for (int p = 0; p < 64; p++) begin
      q = p % 32;
      s = (p < 32) ? l : r;
      if (q >= 1 && q <= 16) v[p] = s[16-q];
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_bits(input int n, input string nm);
    int b;
    b = 0;
    while (cap.size() < n && b < n * 30 + 500) begin
      @(negedge clk);
      b++;
    end
    chk({nm, "_wait"}, 64'(cap.size() >= n), 64'd1);
  endtask

  task automatic wait_cyc(input longint e);
    int b;
    b = 0;
    while (cyc < e && b < 20000) begin
      @(negedge clk);
      b++;
    end
  endtask

  task automatic check_frame(input int f, input logic [15:0] l,
                             input logic [15:0] r, input string nm);
    logic [63:0] ol;
    logic [63:0] od;
    int idx;
    ol = '0;
    od = '0;
    for (int p = 0; p < 64; p++) begin
      idx = 64 * f + p;
      if (idx < cap.size()) begin
        ol[p] = cap[idx][1];
        od[p] = cap[idx][0];
      end
    end
    chk({nm, "_dac"}, od, exp_dac(l, r));
    chk({nm, "_lrck"}, ol, LRCK_EXP);
  endtask

  initial begin
    longint t, rr, s, sp, last_u, ew, ex;
    logic [4:0] ae;
    logic [4:0] ee;
    logic pm, ps;
    logic [15:0] xl, xr;
    int mism, mr, sr, un, badiv, dac1;

    // reset state
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        64'({audio_mclk, audio_sclk, audio_lrck, audio_dac,
             underflow, sample_ready, fifo_level}),
        64'({5'b0, 1'b1, 5'd0}));
    reset_n = 1'b1;

    // free run, no pushes: clock rates, silence, underflow cadence
    mism = 0; mr = 0; sr = 0; un = 0; badiv = 0; dac1 = 0;
    last_u = -1; pm = 1'b0; ps = 1'b0;
    for (int i = 0; i < 24750; i++) begin
      @(negedge clk);
      t  = tog(cyc);
      rr = (t + 1) / 2;
      s  = rr / 4;
      sp = strobes(cyc - 1);
      ee = {t[0], (rr % 4) >= 2, (s % 64) >= 32, 1'b0,
            (s != sp) && (s % 64 == 0)};
      ae = {audio_mclk, audio_sclk, audio_lrck, audio_dac,
            underflow};
      if (ae !== ee) mism++;
      if (audio_mclk && !pm) mr++;
      if (audio_sclk && !ps) sr++;
      pm = audio_mclk;
      ps = audio_sclk;
      if (audio_dac) dac1++;
      if (underflow) begin
        un++;
        if (last_u >= 0 &&
            !((cyc - last_u) == 1546 || (cyc - last_u) == 1547))
          badiv++;
        last_u = cyc;
      end
    end
    chk("freerun_model", 64'(mism), 64'd0);
    chk("mclk_rises", 64'(mr), 64'd4096);
    chk("sclk_rises", 64'(sr), 64'd1024);
    chk("underflow_count", 64'(un), 64'd16);
    chk("underflow_interval", 64'(badiv), 64'd0);
    chk("dac_silent", 64'(dac1), 64'd0);

    // five pushes into a depth-4 FIFO, then play-out order
    vec[0] = '{16'hA5C3, 16'h0F0F, 1'b1, 5'd1};
    vec[1] = '{16'($urandom), 16'($urandom), 1'b1, 5'd2};
    vec[2] = '{16'($urandom), 16'($urandom), 1'b1, 5'd3};
    vec[3] = '{16'($urandom), 16'($urandom), 1'b1, 5'd4};
    vec[4] = '{16'($urandom), 16'($urandom), 1'b0, 5'd4};
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      sample_l = vec[i].l;
      sample_r = vec[i].r;
      sample_valid = 1'b1;
      #1;
      chk($sformatf("ready_before_push%0d", i),
          64'(sample_ready), 64'(vec[i].exp_ready));
      @(negedge clk);
      chk($sformatf("level_after_push%0d", i),
          64'(fifo_level), 64'(vec[i].exp_level));
    end
    sample_valid = 1'b0;
    wait_bits(6 * 64, "fill");
    check_frame(0, 16'h0, 16'h0, "fill_f0");
    for (int i = 0; i < 4; i++)
      check_frame(i + 1, vec[i].l, vec[i].r,
                  $sformatf("fill_f%0d", i + 1));
    check_frame(5, 16'h0, 16'h0, "fill_f5");
    chk("fill_underflows", 64'(und_cnt), 64'd1);
    chk("fill_level_end", 64'(fifo_level), 64'd0);

    // push into empty FIFO on the frame-start edge: no bypass
    reset_dut();
    ew = 1;
    while (strobes(ew) < 64) ew++;
    wait_cyc(ew - 1);
    xl = 16'($urandom);
    xr = 16'($urandom);
    sample_l = xl;
    sample_r = xr;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("race_underflow", 64'(underflow), 64'd1);
    chk("race_level", 64'(fifo_level), 64'd1);
    wait_bits(3 * 64, "race");
    check_frame(1, 16'h0, 16'h0, "race_f1");
    check_frame(2, xl, xr, "race_f2");
    chk("race_underflows", 64'(und_cnt), 64'd1);

    // reset mid-frame with three entries queued
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      sample_l = 16'($urandom);
      sample_r = 16'($urandom);
      sample_valid = 1'b1;
      @(negedge clk);
    end
    sample_valid = 1'b0;
    chk("midrst_level_before", 64'(fifo_level), 64'd3);
    ex = 1;
    while (ex < 20000 && !(strobes(ex) == 20 &&
           rises(ex) % 4 == 2 && tog(ex) % 2 == 1)) ex++;
    wait_cyc(ex);
    chk("midrst_pre_state",
        64'({audio_mclk, audio_sclk, audio_lrck, audio_dac}),
        64'(4'b1100));
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_async_outputs",
        64'({audio_mclk, audio_sclk, audio_lrck, audio_dac,
             underflow, sample_ready, fifo_level}),
        64'({5'b0, 1'b1, 5'd0}));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    xl = 16'($urandom);
    xr = 16'($urandom);
    sample_l = xl;
    sample_r = xr;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    chk("restart_level", 64'(fifo_level), 64'd1);
    wait_bits(3 * 64, "restart");
    check_frame(0, 16'h0, 16'h0, "restart_f0");
    check_frame(1, xl, xr, "restart_f1");
    check_frame(2, 16'h0, 16'h0, "restart_f2");
    chk("restart_underflows", 64'(und_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
